// File: rtl/rr_token_arbiter.sv
// Round-robin arbiter for 16 requesters: a rotating one-hot token sets priority,
// grants are registered, held until release/timeout, and the token parks when idle.
module rr_token_arbiter #(
  parameter int N        = 16,
  parameter int IDW      = 4,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  input  logic [N-1:0]   i_req,
  input  logic [N-1:0]   i_done,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_gnt_id,
  output logic           o_busy,
  output logic           o_timeout,
  output logic [N-1:0]   o_token,
  output logic           o_dbg_state
);

  // Handshake: a requester holds i_req high while it wants the resource; the grant
  // lasts until i_req drops, its i_done bit pulses, or the hold limit expires.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] HOLD_SAT = (MAX_HOLD != 0) ? CW'(MAX_HOLD) : {CW{1'b1}};

  state_t         r_state;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_busy;
  logic           r_timeout;
  logic [N-1:0]   r_token;
  logic [CW-1:0]  r_cnt;

  logic [IDW-1:0] w_tok_idx;
  logic [IDW-1:0] w_try;
  logic [IDW-1:0] w_sel_idx;
  logic           w_found;
  logic [N-1:0]   w_sel_onehot;
  logic           w_rel_req;
  logic           w_rel_done;
  logic           w_hold_hit;
  logic           w_release;
  logic           w_timeout_only;

  always_comb begin
    w_tok_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_token[i]) w_tok_idx = IDW'(i);
    end
  end

  // Search starts at the token position and wraps through the index arithmetic.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_try     = '0;
    for (int i = 0; i < N; i++) begin
      w_try = w_tok_idx + IDW'(i);
      if (!w_found && i_req[w_try]) begin
        w_found   = 1'b1;
        w_sel_idx = w_try;
      end
    end
  end

  assign w_sel_onehot   = {{(N-1){1'b0}}, 1'b1} << w_sel_idx;
  assign w_rel_req      = ~i_req[r_gnt_id];
  assign w_rel_done     = i_done[r_gnt_id];
  assign w_hold_hit     = (MAX_HOLD != 0) && (r_cnt == HOLD_SAT);
  assign w_release      = w_rel_req | w_rel_done | w_hold_hit;
  assign w_timeout_only = w_hold_hit & ~w_rel_req & ~w_rel_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_token   <= {{(N-1){1'b0}}, 1'b1};
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_en && w_found) begin
            r_gnt    <= w_sel_onehot;
            r_gnt_id <= w_sel_idx;
            r_busy   <= 1'b1;
            r_cnt    <= CW'(1);
            r_state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
            r_token   <= {r_gnt[N-2:0], r_gnt[N-1]};
            r_timeout <= w_timeout_only;
          end else if (r_cnt != HOLD_SAT) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_id    = r_gnt_id;
  assign o_busy      = r_busy;
  assign o_timeout   = r_timeout;
  assign o_token     = r_token;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rr_token_arbiter.sv
// Directed bench for rr_token_arbiter: rotation order, wrap search, hold timeout,
// enable gating and asynchronous reset, each against hand-computed values.
module tb_rr_token_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic [15:0] done;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        busy;
  logic        timeout;
  logic [15:0] token;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  rr_token_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_req       (req),
    .i_done      (done),
    .o_gnt       (gnt),
    .o_gnt_id    (gnt_id),
    .o_busy      (busy),
    .o_timeout   (timeout),
    .o_token     (token),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: outputs are sampled and inputs driven at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag, input logic [15:0] exp_tok);
    check({tag, "_gnt"},   gnt,     32'h0);
    check({tag, "_id"},    gnt_id,  32'h0);
    check({tag, "_busy"},  busy,    32'h0);
    check({tag, "_token"}, token,   exp_tok);
  endtask

  initial begin
    logic [15:0] one;
    logic [3:0]  id;
    logic [15:0] exp_tok;
    one   = 16'h0001;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '0;
    done  = '0;
    @(negedge clk);
    @(negedge clk);
    check_idle("rst", 16'h0001);
    check("rst_timeout", timeout, 32'h0);
    check("rst_state", dbg_state, 32'h0);
    rst_n = 1'b1;

    // single request, then drop
    req = 16'h0001;
    step();
    check("t1_gnt", gnt, 32'h0001);
    check("t1_id", gnt_id, 32'h0);
    check("t1_busy", busy, 32'h1);
    check("t1_state", dbg_state, 32'h1);
    req = 16'h0000;
    step();
    check_idle("t1_rel", 16'h0002);
    check("t1_timeout", timeout, 32'h0);

    // full rotation with DONE pulses
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    exp_q.push_back(4'd0);
    req = 16'hFFFF;
    while (exp_q.size() > 0) begin
      id = exp_q.pop_front();
      step();
      check("rr_id", gnt_id, id);
      check("rr_gnt", gnt, one << id);
      done = one << id;
      step();
      exp_tok = (id == 4'd15) ? 16'h0001 : (one << (id + 4'd1));
      check("rr_dead_gnt", gnt, 32'h0);
      check("rr_token", token, exp_tok);
      done = '0;
    end
    req = '0;

    // wrap search from token bit 15
    do_reset();
    req = 16'h4000;
    step();
    check("wr_pre_id", gnt_id, 32'd14);
    req = '0;
    step();
    check("wr_token_8000", token, 32'h8000);
    req = 16'h0006;
    step();
    check("wr_id", gnt_id, 32'd1);
    check("wr_gnt", gnt, 32'h0002);
    req = '0;
    step();
    check("wr_token", token, 32'h0004);

    // hold limit timeout
    req = 16'h0008;
    step();
    for (int c = 1; c <= 8; c++) begin
      check("to_hold_gnt", gnt, 32'h0008);
      check("to_hold_tmo", timeout, 32'h0);
      if (c < 8) step();
    end
    step();
    check("to_rel_gnt", gnt, 32'h0);
    check("to_pulse", timeout, 32'h1);
    check("to_token", token, 32'h0010);
    req = '0;
    step();
    check("to_pulse_end", timeout, 32'h0);

    // timeout coinciding with REQ drop counts as normal release
    req = 16'h0008;
    step();
    for (int c = 1; c <= 8; c++) begin
      check("tn_hold_gnt", gnt, 32'h0008);
      if (c < 8) step();
    end
    req = '0;
    step();
    check("tn_rel_gnt", gnt, 32'h0);
    check("tn_no_pulse", timeout, 32'h0);
    check("tn_token", token, 32'h0010);
    step();
    check("tn_no_pulse2", timeout, 32'h0);

    // enable gating, foreign DONE ignored
    en  = 1'b0;
    req = 16'h0010;
    for (int c = 0; c < 5; c++) begin
      step();
      check("en_block_gnt", gnt, 32'h0);
    end
    check("en_block_token", token, 32'h0010);
    en = 1'b1;
    step();
    check("en_gnt", gnt, 32'h0010);
    check("en_id", gnt_id, 32'd4);
    done = 16'h0001;
    step();
    check("en_foreign_done", gnt, 32'h0010);
    done = 16'h0010;
    step();
    check_idle("en_rel", 16'h0020);
    done = '0;
    req  = '0;

    // asynchronous reset mid-grant
    req = 16'h0020;
    step();
    check("ar_pre_gnt", gnt, 32'h0020);
    rst_n = 1'b0;
    #1;
    check_idle("ar", 16'h0001);
    req   = 16'h8001;
    rst_n = 1'b1;
    step();
    check("ar_post_id", gnt_id, 32'd0);
    check("ar_post_gnt", gnt, 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_token_arbiter.md
Name: rr_token_arbiter

Overview:
- Round-robin arbiter sharing one resource among 16 requesters.
- Priority is set by a rotating one-hot token held in a 16-bit ring register.
- Issues a registered one-hot grant plus its 4-bit encoded index, enforces a hold limit, and parks the token when idle.
- Sits between the requester bank and the shared datapath. The one-hot grant steers the datapath mux; the encoded index tags transactions.

Parameters:
- N, 16, number of requesters (width of REQ/GNT/TOKEN); fixed at 16 for this release.
- IDW, 4, width of encoded grant index (log2 N).
- MAX_HOLD, 8, maximum cycles a grant may be held; 0 disables timeout.
- CW, 4, width of hold counter; must hold MAX_HOLD.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  arbitration enable; low blocks new grants, an existing grant continues.
- REQ  in  16  request vector, level-sensitive, bit i = requester i.
- DONE  in  16  per-requester release pulse; only the bit of the current grantee is honoured.
- GNT  out  16  registered one-hot grant, all-zero when none.
- GNT_ID  out  4  binary index of the set GNT bit, 0 when none.
- BUSY  out  1  high while any GNT bit is set.
- TIMEOUT  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
- TOKEN  out  16  current one-hot priority token.

Behaviour:
- Reset (RST_N low, takes effect immediately):
  - GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0, TOKEN=16'h0001, hold counter=0, state=IDLE.
  - Reset mid-grant drops GNT at once, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE:
  - At each edge with EN=1 and REQ!=0, select the first set REQ bit, searching from the TOKEN position upward with wrap 15->0. The TOKEN position itself has highest priority.
  - Load GNT with that one-hot, GNT_ID with its index, BUSY=1, counter=1, state=GRANT.
  - Latency: REQ seen high at edge k produces GNT high after edge k.
  - EN=0 or REQ=0: stay IDLE; GNT and TOKEN unchanged.
- GRANT: at each edge, release if any of these holds:
  - (a) REQ[g]=0;
  - (b) DONE[g]=1;
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD (timeout).
- On release:
  - GNT=0, GNT_ID=0, BUSY=0, state=IDLE, counter=0.
  - TOKEN becomes the grantee's one-hot rotated left by 1 (bit 15 wraps to bit 0).
  - TIMEOUT=1 for exactly one cycle, only when (c) alone caused the release.
- No release: counter increments, saturating at MAX_HOLD.
- Simultaneous (a)/(b) with (c): counts as a normal release; TIMEOUT stays 0.
- Minimum one dead cycle between grants. Back-to-back grants occur at edges k and k+2.
- DONE bits of non-grantees, and REQ changes of other requesters during GRANT, are ignored.
- EN falling during GRANT has no effect until release; after that, no new grant until EN=1.
- GNT is always zero or one-hot. GNT_ID always equals the encoded GNT. TOKEN is always one-hot.

Test Plan:
- Reset then REQ=16'h0001 -> GNT=16'h0001, GNT_ID=0 one cycle later.
  - Drop REQ -> GNT=0 and TOKEN=16'h0002 after next edge.
- REQ=16'hFFFF held, DONE[g] pulsed each grant -> GNT_ID sequence 0,1,2,...,15,0.
  - Each grant is separated by one idle cycle; TOKEN walks 0x0002..0x8000, then 0x0001.
- TOKEN=16'h8000, REQ=16'h0006 -> GNT_ID=1 (wrap search), then TOKEN=16'h0004.
- MAX_HOLD=8, REQ[3] held, no DONE -> GNT[3] high for 8 cycles, then GNT=0 with TIMEOUT=1 for one cycle.
  - Repeat with REQ[3] dropped on the 8th cycle -> TIMEOUT stays 0.
- EN=0 with REQ=16'h0010 -> GNT stays 0 for 5 cycles; EN=1 -> GNT=16'h0010 one edge later.
- Assert RST_N=0 mid-grant between edges -> GNT=0, TOKEN=16'h0001 immediately.
  - Release reset with REQ=16'h8001 -> GNT_ID=0.
